// File: rtl/cpu_clock_ctrl_if.sv
// Control/status bundle between board switches, CPU top level and cpu_clock_ctrl.
// slave = the clock controller, master = whoever drives the controls.
interface cpu_clock_ctrl_if #(
   parameter int unsigned DIV_W = 32
);
   logic             run_en;
   logic             btn_step;
   logic             halt_req;
   logic             clr_halt;
   logic             div_load;
   logic [DIV_W-1:0] div_value;
   logic             cpu_tick;
   logic             led_tick;
   logic [1:0]       state;
   logic [31:0]      cpu_cycles;

   modport slave (
      input  run_en, btn_step, halt_req, clr_halt, div_load, div_value,
      output cpu_tick, led_tick, state, cpu_cycles
   );

   modport master (
      output run_en, btn_step, halt_req, clr_halt, div_load, div_value,
      input  cpu_tick, led_tick, state, cpu_cycles
   );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// CPU run controller: programmable cpu_tick with run/step/halt modes, plus led_tick.
// Optional macro CPU_CLOCK_CTRL_CYCLE_COUNT_EN enables the cpu_cycles tick counter.
module cpu_clock_ctrl #(
   parameter int unsigned DIV_W       = 32,
   parameter int unsigned DIV_DEFAULT = 10000000,
   parameter int unsigned LED_DIV     = 100000
) (
   input logic             clk_board,
   input logic             rst_n,
   cpu_clock_ctrl_if.slave bus
);

   localparam int unsigned LED_W = $clog2(LED_DIV);

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_RUN     = 2'd1,
      ST_STEP    = 2'd2,
      ST_HALTED  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;
   logic [LED_W-1:0] r_led_cnt;
   logic             r_cpu_tick;
   logic             r_led_tick;
   logic             r_sync1;
   logic             r_sync2;
   logic             r_sync3;
   logic             w_step_pulse;
   logic             w_wrap;
   logic             w_tick_nxt;

   // Button: two-flop synchronizer, third flop holds the previous level for edge detect
   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= bus.btn_step;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_step_pulse = r_sync2 & ~r_sync3;
   assign w_wrap       = (r_cnt == (r_div - DIV_W'(1)));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_STOPPED: begin
            if (bus.halt_req)       w_state_nxt = ST_HALTED;
            else if (bus.run_en)    w_state_nxt = ST_RUN;
            else if (w_step_pulse)  w_state_nxt = ST_STEP;
         end
         ST_RUN: begin
            if (bus.halt_req)       w_state_nxt = ST_HALTED;
            else if (!bus.run_en)   w_state_nxt = ST_STOPPED;
         end
         ST_STEP: begin
            w_state_nxt = bus.halt_req ? ST_HALTED : ST_STOPPED;
         end
         ST_HALTED: begin
            if (bus.clr_halt)       w_state_nxt = ST_STOPPED;
         end
         default:                   w_state_nxt = ST_STOPPED;
      endcase
   end

   // A wrap on the exit edge still registers its tick; a coincident div_load kills it
   assign w_tick_nxt = ((r_state == ST_RUN) && w_wrap && !bus.div_load) ||
                       (r_state == ST_STEP);

   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_STOPPED;
         r_cpu_tick <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cpu_tick <= w_tick_nxt;
      end
   end

   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= DIV_W'(DIV_DEFAULT);
         r_cnt <= '0;
      end else begin
         if (bus.div_load)
            r_div <= (bus.div_value == '0) ? DIV_W'(1) : bus.div_value;
         if (bus.div_load || r_state != ST_RUN || w_state_nxt != ST_RUN || w_wrap)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n) begin
         r_led_cnt  <= '0;
         r_led_tick <= 1'b0;
      end else if (r_led_cnt == LED_W'(LED_DIV - 1)) begin
         r_led_cnt  <= '0;
         r_led_tick <= 1'b1;
      end else begin
         r_led_cnt  <= r_led_cnt + LED_W'(1);
         r_led_tick <= 1'b0;
      end
   end

`ifdef CPU_CLOCK_CTRL_CYCLE_COUNT_EN
   logic [31:0] r_cycles;

   always_ff @(posedge clk_board or negedge rst_n) begin
      if (!rst_n)
         r_cycles <= '0;
      else if (r_cpu_tick)
         r_cycles <= r_cycles + 32'd1;
   end

   assign bus.cpu_cycles = r_cycles;
`else
   assign bus.cpu_cycles = '0;
`endif

   assign bus.cpu_tick = r_cpu_tick;
   assign bus.led_tick = r_led_tick;
   assign bus.state    = r_state;

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
- Run controller for the MIPS CPU clock domain on the FPGA board.
- Replaces the free-running CPU divider with a programmable tick generator that has run, single-step and halt modes.
- Emits one-cycle clock-enable pulses, cpu_tick and led_tick, in the clk_board domain. CPU and display logic qualify their flops with these pulses.
- Sits between the board switches/buttons and the CPU top level.

Parameters:
- DIV_W, 32, width of the divide-ratio register and counter.
- DIV_DEFAULT, 10000000, cpu_tick period in clk_board cycles after reset.
- LED_DIV, 100000, led_tick period in clk_board cycles. Fixed, must be ≥2.

Ports:
- clk_board  input  1  board clock; all logic on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- run_en  input  1  level; synchronous to clk_board; 1 = free-run the CPU
- btn_step  input  1  raw push button; asynchronous
- halt_req  input  1  pulse/level from CPU (break/syscall halt); synchronous
- clr_halt  input  1  pulse; leave HALTED
- div_load  input  1  pulse; load div_value
- div_value  input  DIV_W  new cpu_tick period in cycles
- cpu_tick  output  1  one-cycle CPU clock-enable pulse
- led_tick  output  1  one-cycle display-scan enable pulse
- state  output  2  0=STOPPED, 1=RUN, 2=STEP, 3=HALTED
- cpu_cycles  output  32  count of issued cpu_ticks (see Optional Feature)

Behaviour:
Reset (rst_n=0, asynchronous):
- state=STOPPED; cpu_tick=0; led_tick=0.
- div_reg=DIV_DEFAULT; both counters=0; synchronizer flops=0; cpu_cycles=0.

btn_step handling:
- 2-flop synchronizer, then a rising-edge detector.
- step_pulse is internal, one cycle wide, and asserted on the 3rd clk_board edge after btn_step goes high.
- Holding the button gives exactly one pulse.

div_reg load:
- On div_load, div_reg <= (div_value==0 ? 1 : div_value).
- The cpu counter clears in the same cycle, so the new period starts cleanly.
- div_load has priority over a coincident counter wrap. The tick for that cycle is suppressed.

RUN counting:
- cpu counter increments each cycle.
- When counter==div_reg-1: counter <= 0 and cpu_tick=1 on the following cycle (registered output).
- div_reg=1 gives cpu_tick high every cycle.
- First tick after entering RUN arrives div_reg cycles after entry.

FSM transitions (evaluated each edge, priority top-down):
- STOPPED: halt_req -> HALTED. Else run_en -> RUN (counter cleared). Else step_pulse -> STEP. step_pulse is ignored while run_en=1.
- RUN: halt_req -> HALTED. Else !run_en -> STOPPED. Counter is cleared on exit; a tick already registered still appears.
- STEP: lasts exactly one cycle. cpu_tick=1 on the cycle after STEP is entered. Next state is HALTED if halt_req, else STOPPED. Exactly one tick per step press.
- HALTED: cpu_tick held 0. clr_halt -> STOPPED. run_en and step_pulse are ignored. If halt_req and clr_halt are both high, clr_halt wins; halt_req is re-sampled next cycle.

Tick guarantees:
- cpu_tick is never high in two consecutive cycles unless div_reg=1 in RUN.
- cpu_tick is never high while state=HALTED except a tick registered on the edge of entry.

led_tick:
- Free-running counter, independent of the FSM.
- led_tick=1 for one cycle every LED_DIV cycles; first pulse at cycle LED_DIV after reset release.

Reset mid-operation:
- Immediate return to the reset values above.
- No partial tick is emitted after rst_n deasserts.

Optional Feature:
- Macro: CPU_CLOCK_CTRL_CYCLE_COUNT_EN.
- Defined: cpu_cycles increments by 1 on every cycle cpu_tick=1. It wraps 0xFFFFFFFF -> 0 and is cleared only by reset.
- Not defined: cpu_cycles is tied to 0 and the counter is not synthesized. The port remains so the top level is unchanged.

Test Plan:
- Reset then release: state=0, cpu_tick=0 for 100 cycles. led_tick first high at cycle LED_DIV (use LED_DIV=8 in bench), then every 8.
- div_load with div_value=4, run_en=1: state=1 next cycle. cpu_tick high at cycles 4, 8, 12 after entry. Drop run_en: state=0 and no further ticks.
- run_en=0, btn_step held high 50 cycles: exactly one cpu_tick, about 4 cycles after the rise. state goes 0->2->0.
- RUN with div=3, pulse halt_req: state=3 and no ticks for 20 cycles. run_en and btn_step are ignored. clr_halt pulse -> state=0.
- div_load with div_value=0 in RUN: cpu_tick every cycle. div_load coincident with a wrap: that tick is suppressed.
- rst_n low mid-RUN, asynchronous and not clock-aligned: outputs clear immediately. With the macro defined, cpu_cycles returns to 0 and counts 5 after 5 ticks.
